dtree_feature_loader: RTL and testbench
=======================================

DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

Interface
REQ-001 The module SHALL declare parameter REC_LEN, default 279, meaning feature bytes per record (indices 0..REC_LEN-1).
REQ-002 The module SHALL declare parameter CNT_W, default 16, meaning width of the completed-record and error counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  upstream feature byte valid.
REQ-006 s_ready  output  1  module accepts s_data this cycle.
REQ-007 s_data  input  8  feature byte, two's-complement.
REQ-008 s_last  input  1  final byte of record.
REQ-009 X6, X13, X169, X236, X251, X260, X278  output  8 each  held feature bytes for the classifier.
REQ-010 m_valid  output  1  held feature bank is valid.
REQ-011 m_ready  input  1  classifier consumes bank.
REQ-012 err_short, err_long  output  1 each  one-cycle malformed-record pulses.
REQ-013 rec_cnt, err_cnt  output  CNT_W each  completed-record and malformed-record counts.

Function
REQ-014 A beat SHALL be transferred when s_valid && s_ready; idx (9 bits) SHALL count beats within the record, starting at 0.
REQ-015 On a beat whose idx equals 6, 13, 169, 236, 251, 260 or 278, s_data SHALL be written to the matching shadow register; other beats SHALL be discarded.
REQ-016 FSM states: COLLECT, FLUSH, WAIT; reset state COLLECT.
REQ-017 COLLECT: s_ready=1; a beat with s_last=1 and idx==REC_LEN-1 SHALL complete the record.
REQ-018 COLLECT: a beat with s_last=1 and idx<REC_LEN-1 SHALL pulse err_short the next cycle, clear idx, stay in COLLECT, and leave the output bank unchanged.
REQ-019 COLLECT: a beat with s_last=0 and idx==REC_LEN-1 SHALL pulse err_long the next cycle and enter FLUSH.
REQ-020 FLUSH: s_ready=1, beats discarded; the beat with s_last=1 SHALL clear idx and return to COLLECT.
REQ-021 On completion, if m_valid==0 or (m_valid && m_ready) in that cycle, the shadow registers SHALL copy to the output bank at the same edge, with m_valid=1 the next cycle; idx cleared, stay COLLECT.
REQ-022 On completion with m_valid && !m_ready, the FSM SHALL enter WAIT; WAIT SHALL drive s_ready=0.
REQ-023 WAIT: when m_ready=1, shadow SHALL copy to the output bank, m_valid SHALL stay 1, and the FSM SHALL return to COLLECT.
REQ-024 m_valid && m_ready with no pending completion SHALL clear m_valid at the next edge.
REQ-025 Outputs X* SHALL be stable while m_valid=1 and m_ready=0.
REQ-026 Latency: completing beat to m_valid=1 SHALL be 1 cycle when the bank is free.
REQ-027 rec_cnt SHALL increment on each bank load; err_cnt SHALL increment on each err_short or err_long pulse; both SHALL wrap modulo 2^CNT_W.
REQ-028 err_short and err_long SHALL never assert in the same cycle.

Reset
REQ-029 rst_n low SHALL asynchronously force FSM=COLLECT, idx=0, shadow and output bank=0, m_valid=0, err pulses=0, counters=0.
REQ-030 Reset mid-record SHALL discard the partial record; the first beat after release SHALL be idx 0.
REQ-031 s_ready SHALL be 0 while rst_n is low.

Structure
REQ-032 A shared package dtree_loader_pkg SHALL hold the FSM state enum, the seven feature index constants, and REC_LEN default.
REQ-033 One sub-module dtree_feature_bank SHALL hold the seven shadow and output registers with write-select and load inputs; FSM and counters stay in the top.

Verification
REQ-034 Record of 279 bytes with byte i = i[7:0], m_ready=1 -> m_valid one cycle after last beat; X6=0x06, X13=0x0D, X169=0xA9, X236=0xEC, X251=0xFB, X260=0x04, X278=0x16; rec_cnt=1.
REQ-035 s_last at idx 100 -> err_short pulse, err_cnt=1, m_valid stays 0; next full record loads normally.
REQ-036 300-byte record, s_last at byte 299 -> err_long at idx 278, bytes discarded to byte 299, err_cnt=1, output bank unchanged.
REQ-037 Two back-to-back records, m_ready=0 -> second completion enters WAIT, s_ready=0; raising m_ready loads record 2 same edge, m_valid stays 1, rec_cnt=2.
REQ-038 rst_n low at idx 150 -> all outputs 0 immediately; 279-byte record after release loads correctly.

Source files
------------

// File: rtl/dtree_loader_pkg.sv
// Shared types and constants for the decision-tree feature loader:
// FSM states, the seven feature byte positions and a position-match helper.
package dtree_loader_pkg;

  localparam int REC_LEN_DEF = 279;
  localparam int IDX_W       = 9;
  localparam int NUM_FEAT    = 7;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  typedef logic [2:0] feat_sel_t;

  typedef struct packed {
    logic      hit;
    feat_sel_t sel;
  } feat_match_t;

  // Bank slot k holds the byte at record position FEAT_IDX[k].
  localparam logic [IDX_W-1:0] FEAT_IDX [NUM_FEAT] = '{
    9'd6, 9'd13, 9'd169, 9'd236, 9'd251, 9'd260, 9'd278
  };

  function automatic feat_match_t feat_match(input logic [IDX_W-1:0] idx);
    feat_match_t r;
    r.hit = 1'b0;
    r.sel = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (idx == FEAT_IDX[k]) begin
        r.hit = 1'b1;
        r.sel = feat_sel_t'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dtree_feature_bank.sv
// Shadow registers filled during a record, and the output bank they are
// copied into when a completed record is handed to the classifier.
module dtree_feature_bank
  import dtree_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  feat_sel_t                    wr_sel_i,
  input  logic [7:0]                   wr_data_i,
  input  logic                         load_i,
  output logic [NUM_FEAT-1:0][7:0]     bank_o
);

  logic [NUM_FEAT-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_FEAT-1:0][7:0] bank_q, bank_d;

  // Loading from shadow_d lets the final byte of a record (position 278)
  // land in the output bank on the same edge it is written.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) begin
      shadow_d[wr_sel_i] = wr_data_i;
    end
    bank_d = load_i ? shadow_d : bank_q;
  end

  // NOTE: these feature registers are reset on purpose so the bank reads
  // as defined zeros after reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      bank_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
    end
  end

  assign bank_o = bank_q;

endmodule

// File: rtl/dtree_feature_loader.sv
// Streams feature bytes of fixed-length records, captures seven feature
// positions and hands them to the classifier through a held, valid bank.
module dtree_feature_loader
  import dtree_loader_pkg::*;
#(
  parameter int REC_LEN = REC_LEN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic [7:0]       X6,
  output logic [7:0]       X13,
  output logic [7:0]       X169,
  output logic [7:0]       X236,
  output logic [7:0]       X251,
  output logic [7:0]       X260,
  output logic [7:0]       X278,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     m_valid_q, m_valid_d;
  logic                     err_short_q, err_short_d;
  logic                     err_long_q, err_long_d;
  logic [CNT_W-1:0]         rec_cnt_q, rec_cnt_d;
  logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;

  logic                     beat;
  logic                     bank_free;
  logic                     load;
  logic                     wr_en;
  feat_match_t              match;
  logic [NUM_FEAT-1:0][7:0] bank;

  assign s_ready   = rst_n && (state_q != ST_WAIT);
  assign beat      = s_valid && s_ready;
  assign bank_free = !m_valid_q || m_ready;
  assign match     = feat_match(idx_q);
  assign wr_en     = beat && (state_q == ST_COLLECT) && match.hit;

  // NOTE: every signal driven here gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    m_valid_d   = m_valid_q && !m_ready;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    rec_cnt_d   = rec_cnt_q;
    err_cnt_d   = err_cnt_q;
    load        = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (beat) begin
          if (s_last && idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bank_free) begin
              load      = 1'b1;
              m_valid_d = 1'b1;
              rec_cnt_d = rec_cnt_q + CNT_W'(1);
            end else begin
              state_d = ST_WAIT;
            end
          end else if (s_last) begin
            idx_d       = '0;
            err_short_d = 1'b1;
            err_cnt_d   = err_cnt_q + CNT_W'(1);
          end else if (idx_q == LAST_IDX) begin
            err_long_d = 1'b1;
            err_cnt_d  = err_cnt_q + CNT_W'(1);
            state_d    = ST_FLUSH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (beat && s_last) begin
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_WAIT: begin
        // The held record is still valid here; m_ready swaps in the new one.
        if (m_ready) begin
          load      = 1'b1;
          m_valid_d = 1'b1;
          rec_cnt_d = rec_cnt_q + CNT_W'(1);
          state_d   = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      m_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      rec_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_valid_q   <= m_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      rec_cnt_q   <= rec_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  dtree_feature_bank u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_sel_i  (match.sel),
    .wr_data_i (s_data),
    .load_i    (load),
    .bank_o    (bank)
  );

  assign X6        = bank[0];
  assign X13       = bank[1];
  assign X169      = bank[2];
  assign X236      = bank[3];
  assign X251      = bank[4];
  assign X260      = bank[5];
  assign X278      = bank[6];
  assign m_valid   = m_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign rec_cnt   = rec_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader: directed record scenarios with literal
// expectations plus randomized records checked against a record-level model.
module tb_dtree_feature_loader;

  localparam int REC_LEN = 279;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [7:0]       s_data = 8'h00;
  logic             s_last = 1'b0;
  logic [7:0]       X6, X13, X169, X236, X251, X260, X278;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             err_short, err_long;
  logic [CNT_W-1:0] rec_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_mr  = 1'b0;
  bit gaps     = 1'b0;

  dtree_feature_loader #(.REC_LEN(REC_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .X6        (X6),
    .X13       (X13),
    .X169      (X169),
    .X236      (X236),
    .X251      (X251),
    .X260      (X260),
    .X278      (X278),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_short (err_short),
    .err_long  (err_long),
    .rec_cnt   (rec_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- record-level reference model ----------------
  int         feat_pos [7] = '{6, 13, 169, 236, 251, 260, 278};
  logic [7:0] rec_q [$];
  bit         discarding, pending;
  logic [7:0] pend_feat [7];
  logic [7:0] exp_bank [7];
  bit         exp_mvalid, exp_es, exp_el;
  int         exp_rec, exp_err;

  task automatic model_reset();
    rec_q.delete();
    discarding = 0; pending = 0; exp_mvalid = 0; exp_es = 0; exp_el = 0;
    exp_rec = 0; exp_err = 0;
    for (int k = 0; k < 7; k++) begin
      exp_bank[k] = 8'h00;
      pend_feat[k] = 8'h00;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit free;
        free   = !exp_mvalid || m_ready;
        exp_es = 0;
        exp_el = 0;
        if (exp_mvalid && m_ready) exp_mvalid = 0;
        if (pending) begin
          if (m_ready) begin
            exp_bank = pend_feat;
            exp_mvalid = 1;
            exp_rec++;
            pending = 0;
          end
        end else if (s_valid) begin
          if (discarding) begin
            if (s_last) discarding = 0;
          end else begin
            rec_q.push_back(s_data);
            if (s_last) begin
              if (rec_q.size() == REC_LEN) begin
                for (int k = 0; k < 7; k++) pend_feat[k] = rec_q[feat_pos[k]];
                if (free) begin
                  exp_bank = pend_feat;
                  exp_mvalid = 1;
                  exp_rec++;
                end else begin
                  pending = 1;
                end
              end else begin
                exp_es = 1;
                exp_err++;
              end
              rec_q.delete();
            end else if (rec_q.size() == REC_LEN) begin
              exp_el = 1;
              exp_err++;
              discarding = 1;
              rec_q.delete();
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("s_ready", s_ready, rst_n && !pending);
      check("m_valid", m_valid, exp_mvalid);
      check("err_short", err_short, exp_es);
      check("err_long", err_long, exp_el);
      check("err_exclusive", err_short && err_long, 1'b0);
      check("rec_cnt", rec_cnt, CNT_W'(exp_rec));
      check("err_cnt", err_cnt, CNT_W'(exp_err));
      check("X6", X6, exp_bank[0]);
      check("X13", X13, exp_bank[1]);
      check("X169", X169, exp_bank[2]);
      check("X236", X236, exp_bank[3]);
      check("X251", X251, exp_bank[4]);
      check("X260", X260, exp_bank[5]);
      check("X278", X278, exp_bank[6]);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mr) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    bit ok;
    s_valid = 1'b1; s_data = d; s_last = l; guard = 0;
    do begin
      @(negedge clk);
      ok = s_ready;
      tick();
      guard++;
    end while (!ok && guard < 2000);
    if (!ok) check("beat_timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(i + 1);
      2:       return 8'(i + 16);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic send_rec(input int len, input int mode);
    for (int i = 0; i < len; i++) send_byte(pat(mode, i), i == len - 1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #20;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_rec_cnt", rec_cnt, 16'd0);

    // Full ramp record, bank free.
    m_ready = 1'b1;
    send_rec(REC_LEN, 0);
    check("t1_m_valid", m_valid, 1'b1);
    check("t1_X6", X6, 8'h06);
    check("t1_X13", X13, 8'h0D);
    check("t1_X169", X169, 8'hA9);
    check("t1_X236", X236, 8'hEC);
    check("t1_X251", X251, 8'hFB);
    check("t1_X260", X260, 8'h04);
    check("t1_X278", X278, 8'h16);
    check("t1_rec_cnt", rec_cnt, 16'd1);

    // Short record then a good one.
    do_reset();
    m_ready = 1'b1;
    send_rec(101, 0);
    check("t2_err_short", err_short, 1'b1);
    check("t2_err_cnt", err_cnt, 16'd1);
    check("t2_m_valid", m_valid, 1'b0);
    send_rec(REC_LEN, 1);
    check("t2_X6", X6, 8'h07);
    check("t2_X278", X278, 8'h17);
    check("t2_rec_cnt", rec_cnt, 16'd1);

    // Over-long record while a bank is held.
    do_reset();
    m_ready = 1'b0;
    send_rec(REC_LEN, 0);
    for (int i = 0; i < 300; i++) begin
      send_byte(pat(2, i), i == 299);
      if (i == REC_LEN - 1) begin
        check("t3_err_long", err_long, 1'b1);
        check("t3_err_cnt", err_cnt, 16'd1);
      end
    end
    check("t3_X6", X6, 8'h06);
    check("t3_X278", X278, 8'h16);
    check("t3_m_valid", m_valid, 1'b1);
    check("t3_rec_cnt", rec_cnt, 16'd1);

    // Back-to-back records with the bank stalled.
    do_reset();
    m_ready = 1'b0;
    send_rec(REC_LEN, 0);
    send_rec(REC_LEN, 1);
    check("t4_s_ready_wait", s_ready, 1'b0);
    repeat (2) tick();
    check("t4_X6_held", X6, 8'h06);
    check("t4_m_valid_held", m_valid, 1'b1);
    m_ready = 1'b1;
    tick();
    check("t4_m_valid", m_valid, 1'b1);
    check("t4_X6", X6, 8'h07);
    check("t4_rec_cnt", rec_cnt, 16'd2);
    check("t4_s_ready", s_ready, 1'b1);
    m_ready = 1'b0;

    // Reset in the middle of a record.
    do_reset();
    send_rec(REC_LEN, 0);
    send_rec(150, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_m_valid", m_valid, 1'b0);
    check("t5_X6", X6, 8'h00);
    check("t5_X278", X278, 8'h00);
    check("t5_rec_cnt", rec_cnt, 16'd0);
    check("t5_s_ready", s_ready, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_rec(REC_LEN, 2);
    check("t5_X6_after", X6, 8'h16);
    check("t5_X278_after", X278, 8'h26);
    check("t5_rec_cnt_after", rec_cnt, 16'd1);

    // Randomized records, gaps and back-pressure.
    do_reset();
    rand_mr = 1'b1;
    gaps    = 1'b1;
    send_rec(278, 3);
    send_rec(280, 3);
    send_rec(1, 3);
    send_rec(REC_LEN, 3);
    for (int r = 0; r < 30; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)      send_rec(REC_LEN, 3);
      else if (sel < 8) send_rec($urandom_range(1, REC_LEN - 1), 3);
      else              send_rec($urandom_range(REC_LEN + 1, 330), 3);
    end
    rand_mr = 1'b0;
    m_ready = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
